// File: rtl/countdown_timer.sv
// Day/hour/minute/second countdown timer with prescaler, pause/resume and expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the shadow registers on expiry instead of stopping.
module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [7:0] set_day_i,
  input  logic [7:0] set_hour_i,
  input  logic [7:0] set_minute_i,
  input  logic [7:0] set_second_i,
  output logic [7:0] day_o,
  output logic [7:0] hour_o,
  output logic [7:0] minute_o,
  output logic [7:0] second_o,
  output logic       running_o,
  output logic       done_o,
  output logic       expired_o
);

  localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMax = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [7:0] day_q, day_d, hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0] sh_day_q, sh_day_d, sh_hour_q, sh_hour_d, sh_min_q, sh_min_d, sh_sec_q, sh_sec_d;
  logic [7:0] dec_day, dec_hour, dec_min, dec_sec;
  logic       done_q, done_d;
  logic       cnt_zero, dec_zero, tick;

  function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] max);
    return (v > max) ? max : v;
  endfunction

  assign cnt_zero = (day_q == 8'd0) && (hour_q == 8'd0) && (min_q == 8'd0) && (sec_q == 8'd0);
  assign tick     = (state_q == StRun) && (pcnt_q == PMax);

  // Borrow chain; only evaluated on a tick, where the count is never zero.
  always_comb begin
    dec_day  = day_q;
    dec_hour = hour_q;
    dec_min  = min_q;
    dec_sec  = sec_q;
    if (sec_q != 8'd0) begin
      dec_sec = sec_q - 8'd1;
    end else begin
      dec_sec = 8'd59;
      if (min_q != 8'd0) begin
        dec_min = min_q - 8'd1;
      end else begin
        dec_min = 8'd59;
        if (hour_q != 8'd0) begin
          dec_hour = hour_q - 8'd1;
        end else begin
          dec_hour = 8'd23;
          dec_day  = day_q - 8'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_day == 8'd0) && (dec_hour == 8'd0) && (dec_min == 8'd0) &&
                    (dec_sec == 8'd0);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StPause: begin
          if (!stop_i && start_i && !cnt_zero) state_d = StRun;
        end
        StRun: begin
          if (stop_i) begin
            state_d = StPause;
          end else if (tick && dec_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            state_d = StRun;
`else
            state_d = StDone;
`endif
          end
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    running_o = (state_q == StRun);
    expired_o = (state_q == StDone);
    done_o    = done_q;
    day_o     = day_q;
    hour_o    = hour_q;
    minute_o  = min_q;
    second_o  = sec_q;
  end

  // Datapath next-state: counters, shadows, prescaler, done pulse
  always_comb begin
    day_d     = day_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    sh_day_d  = sh_day_q;
    sh_hour_d = sh_hour_q;
    sh_min_d  = sh_min_q;
    sh_sec_d  = sh_sec_q;
    pcnt_d    = pcnt_q;
    done_d    = 1'b0;
    if (load_i) begin
      day_d     = clamp(set_day_i, 8'd29);
      hour_d    = clamp(set_hour_i, 8'd23);
      min_d     = clamp(set_minute_i, 8'd59);
      sec_d     = clamp(set_second_i, 8'd59);
      sh_day_d  = day_d;
      sh_hour_d = hour_d;
      sh_min_d  = min_d;
      sh_sec_d  = sec_d;
      pcnt_d    = '0;
    end else if (state_q == StRun && !stop_i) begin
      if (tick) begin
        pcnt_d = '0;
        done_d = dec_zero;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (dec_zero) begin
          day_d  = sh_day_q;
          hour_d = sh_hour_q;
          min_d  = sh_min_q;
          sec_d  = sh_sec_q;
        end else begin
          day_d  = dec_day;
          hour_d = dec_hour;
          min_d  = dec_min;
          sec_d  = dec_sec;
        end
`else
        day_d  = dec_day;
        hour_d = dec_hour;
        min_d  = dec_min;
        sec_d  = dec_sec;
`endif
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      day_q     <= 8'd0;
      hour_q    <= 8'd0;
      min_q     <= 8'd0;
      sec_q     <= 8'd0;
      sh_day_q  <= 8'd0;
      sh_hour_q <= 8'd0;
      sh_min_q  <= 8'd0;
      sh_sec_q  <= 8'd0;
      pcnt_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      day_q     <= day_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      sh_day_q  <= sh_day_d;
      sh_hour_q <= sh_hour_d;
      sh_min_q  <= sh_min_d;
      sh_sec_q  <= sh_sec_d;
      pcnt_q    <= pcnt_d;
      done_q    <= done_d;
    end
  end

endmodule
